up_down_counter_mod: RTL and testbench

//   Parametrised modulo-N up/down counter.

---
 rtl/up_down_counter_mod.sv | 90 +++++++++
 tb/tb_up_down_counter_mod.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod: parametrised modulo-N up/down counter with count enable,
// synchronous parallel load (clamped to MOD_MAX), a combinational terminal-count
// flag and a registered one-cycle wrap pulse for cascading stages.
//
// Build option: define UDC_SATURATE_EN to make the counter saturate at MOD_MAX
// (up) and 0 (down) instead of wrapping; wrap is then constantly 0 while tc
// still flags the saturation point.
//
// Control priority at every rising CLK edge: Reset > load > en count > hold.
module up_down_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MOD_MAX = 15
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    // Highest count value expressed in the counter's own width; all arithmetic
    // stays WIDTH bits wide, so no carry bit is needed even when MOD_MAX is all ones.
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count_q == MAX_V);
    assign at_zero = (count_q == '0);

    // Terminal count: the next enabled step in the current direction would wrap
    // (or saturate).
    assign tc = en & ((mode & at_max) | (~mode & at_zero));

    // Next-state selection: load beats counting; wrap only pulses on a wrapping step.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (mode) begin
                if (at_max) begin
`ifdef UDC_SATURATE_EN
                    count_d = MAX_V;
`else
                    count_d = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef UDC_SATURATE_EN
                    count_d = '0;
`else
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Q    = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// tb_up_down_counter_mod: directed checks of the up/down counter on three builds:
// A (WIDTH=4, MOD_MAX=15), B (WIDTH=5, MOD_MAX=9) and C (WIDTH=1, MOD_MAX=0).
// Inputs change 1 ns after each rising edge; every checked vector pushes the
// state expected at the following falling edge: Q and wrap as left by earlier
// edges, tc as produced by the inputs just applied.
module tb_up_down_counter_mod;

    localparam int SEL_A = 0;
    localparam int SEL_B = 1;
    localparam int SEL_C = 2;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;

    logic [3:0] q_a;
    logic       tc_a, wrap_a;
    logic [4:0] q_b;
    logic       tc_b, wrap_b;
    logic [0:0] q_c;
    logic       tc_c, wrap_c;

    // Entry layout: {inv_only, sel[1:0], q[4:0], wrap, tc}
    logic [9:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Clock
    always #5 CLK = ~CLK;

    up_down_counter_mod #(.WIDTH(4), .MOD_MAX(15)) u_a (
        .CLK(CLK), .Reset(Reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val[3:0]), .Q(q_a), .tc(tc_a), .wrap(wrap_a)
    );

    up_down_counter_mod #(.WIDTH(5), .MOD_MAX(9)) u_b (
        .CLK(CLK), .Reset(Reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .Q(q_b), .tc(tc_b), .wrap(wrap_b)
    );

    up_down_counter_mod #(.WIDTH(1), .MOD_MAX(0)) u_c (
        .CLK(CLK), .Reset(Reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val[0:0]), .Q(q_c), .tc(tc_c), .wrap(wrap_c)
    );

    // Driver: apply one vector and, if chk, push the state expected at the next falling edge.
    task automatic drive(input bit chk, input int sel, input bit r, input bit e,
                         input bit m, input bit l, input int lv,
                         input int eq, input bit ew, input bit et);
        @(posedge CLK);
        #1;
        Reset    = r;
        en       = e;
        mode     = m;
        load     = l;
        load_val = 5'(lv);
        if (chk) exp_q.push_back({1'b0, 2'(sel), 5'(eq), ew, et});
    endtask

    // Driver: random vector on build B, checked only against the Q <= 9 invariant.
    task automatic drive_rand_b();
        @(posedge CLK);
        #1;
        Reset    = 1'b0;
        en       = 1'($urandom_range(0, 1));
        mode     = 1'($urandom_range(0, 1));
        load     = ($urandom_range(0, 7) == 0);
        load_val = 5'($urandom_range(0, 31));
        exp_q.push_back({1'b1, 2'(SEL_B), 5'd9, 1'b0, 1'b0});
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        logic [9:0] e;
        logic [4:0] oq;
        logic       ow, ot;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e[8:7])
                    2'd0:    begin oq = {1'b0, q_a};  ow = wrap_a; ot = tc_a; end
                    2'd1:    begin oq = q_b;          ow = wrap_b; ot = tc_b; end
                    default: begin oq = {4'b0, q_c};  ow = wrap_c; ot = tc_c; end
                endcase
                n_cmp++;
                if (e[9]) begin
                    if (oq > e[6:2]) begin
                        n_bad++;
                        $display("FAIL q_range t=%0t: Q=%0d exceeds MOD_MAX %0d", $time, oq, e[6:2]);
                    end
                end else if ({oq, ow, ot} !== e[6:0]) begin
                    n_bad++;
                    $display("FAIL obs_sel%0d t=%0t: got Q=%0d wrap=%0b tc=%0b, expected Q=%0d wrap=%0b tc=%0b",
                             e[8:7], $time, oq, ow, ot, e[6:2], e[1], e[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin : stimulus
`ifdef UDC_SATURATE_EN
        // Saturation on build A
        drive(0, SEL_A, 1, 0, 0, 0, 0,   0, 0, 0);
        drive(1, SEL_A, 0, 0, 0, 1, 14,  0, 0, 0);
        drive(1, SEL_A, 0, 1, 1, 0, 0,  14, 0, 0);
        drive(1, SEL_A, 0, 1, 1, 0, 0,  15, 0, 1);
        drive(1, SEL_A, 0, 1, 1, 0, 0,  15, 0, 1);
        drive(1, SEL_A, 0, 0, 0, 1, 1,  15, 0, 0);
        drive(1, SEL_A, 0, 1, 0, 0, 0,   1, 0, 0);
        drive(1, SEL_A, 0, 1, 0, 0, 0,   0, 0, 1);
        drive(1, SEL_A, 0, 1, 0, 0, 0,   0, 0, 1);
        drive(1, SEL_A, 0, 0, 0, 0, 0,   0, 0, 0);
`else
        // Reset two edges, then count up 17 edges with wrap at 15 -> 0
        drive(0, SEL_A, 1, 0, 0, 0, 0,   0, 0, 0);
        drive(1, SEL_A, 1, 0, 0, 0, 0,   0, 0, 0);
        for (int i = 0; i < 17; i++)
            drive(1, SEL_A, 0, 1, 1, 0, 0, i % 16, (i == 16), (i == 15));
        drive(1, SEL_A, 1, 0, 0, 0, 0,   1, 0, 0);
        // Count down from 0 with wrap to 15
        drive(1, SEL_A, 0, 1, 0, 0, 0,   0, 0, 1);
        drive(1, SEL_A, 0, 1, 0, 0, 0,  15, 1, 0);
        drive(1, SEL_A, 0, 1, 0, 0, 0,  14, 0, 0);
        drive(1, SEL_A, 0, 0, 0, 0, 0,  13, 0, 0);
        // Load, count, load beats en
        drive(1, SEL_A, 0, 0, 0, 1, 9,  13, 0, 0);
        drive(1, SEL_A, 0, 1, 1, 0, 0,   9, 0, 0);
        drive(1, SEL_A, 0, 1, 1, 1, 3,  10, 0, 0);
        drive(1, SEL_A, 0, 0, 0, 0, 0,   3, 0, 0);
        // Load on the cycle wrap is high clears wrap
        drive(1, SEL_A, 0, 0, 0, 1, 15,  3, 0, 0);
        drive(1, SEL_A, 0, 1, 1, 0, 0,  15, 0, 1);
        drive(1, SEL_A, 0, 1, 1, 1, 0,   0, 1, 0);
        drive(1, SEL_A, 0, 0, 0, 0, 0,   0, 0, 0);
        // Mode changes between enabled edges
        drive(1, SEL_A, 0, 1, 1, 0, 0,   0, 0, 0);
        drive(1, SEL_A, 0, 1, 0, 0, 0,   1, 0, 0);
        drive(1, SEL_A, 0, 0, 1, 0, 0,   0, 0, 0);
        drive(1, SEL_A, 0, 1, 0, 0, 0,   0, 0, 1);
        drive(1, SEL_A, 0, 0, 0, 0, 0,  15, 1, 0);
        // Reset mid-count beats load and en
        drive(1, SEL_A, 1, 0, 0, 0, 0,  15, 0, 0);
        for (int i = 0; i < 6; i++)
            drive(1, SEL_A, 0, 1, 1, 0, 0, i, 0, 0);
        drive(1, SEL_A, 1, 1, 1, 1, 12,  6, 0, 0);
        drive(1, SEL_A, 0, 1, 1, 0, 0,   0, 0, 0);
        drive(1, SEL_A, 0, 0, 0, 0, 0,   1, 0, 0);
        // Build B: MOD_MAX=9 wrap and load clamp
        drive(0, SEL_B, 1, 0, 0, 0, 0,   0, 0, 0);
        drive(1, SEL_B, 0, 0, 0, 1, 8,   0, 0, 0);
        drive(1, SEL_B, 0, 1, 1, 0, 0,   8, 0, 0);
        drive(1, SEL_B, 0, 1, 1, 0, 0,   9, 0, 1);
        drive(1, SEL_B, 0, 0, 0, 1, 20,  0, 1, 0);
        drive(1, SEL_B, 0, 1, 0, 0, 0,   9, 0, 0);
        drive(1, SEL_B, 0, 1, 1, 1, 31,  8, 0, 0);
        drive(1, SEL_B, 0, 1, 1, 0, 0,   9, 0, 1);
        drive(1, SEL_B, 0, 0, 0, 0, 0,   0, 1, 0);
        for (int i = 0; i < 40; i++) drive_rand_b();
        // Build C: MOD_MAX=0 pulses wrap on every enabled edge
        drive(0, SEL_C, 1, 0, 0, 0, 0,   0, 0, 0);
        drive(1, SEL_C, 0, 1, 1, 0, 0,   0, 0, 1);
        drive(1, SEL_C, 0, 1, 0, 0, 0,   0, 1, 1);
        drive(1, SEL_C, 0, 0, 0, 0, 0,   0, 1, 0);
        drive(1, SEL_C, 0, 0, 0, 1, 1,   0, 0, 0);
        drive(1, SEL_C, 0, 0, 0, 0, 0,   0, 0, 0);
`endif
        // Drain the scoreboard with a cycle budget
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
